// File: rtl/ldpcenc_pkg.sv
// rtl/ldpcenc_pkg.sv - state encodings and code-geometry lookups for the LDPC encoder controller
package ldpcenc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MSG  = 2'd1,
      ST_WAIT = 2'd2,
      ST_PRT  = 2'd3
   } state_t;

   localparam logic [1:0] LEN_648  = 2'd0;
   localparam logic [1:0] LEN_1296 = 2'd1;
   localparam logic [1:0] LEN_1944 = 2'd2;
   localparam logic [1:0] LEN_BAD  = 2'd3;

   localparam logic [1:0] RATE_1_2 = 2'd0;
   localparam logic [1:0] RATE_2_3 = 2'd1;
   localparam logic [1:0] RATE_3_4 = 2'd2;
   localparam logic [1:0] RATE_5_6 = 2'd3;

   function automatic logic [4:0] k_syms(input logic [1:0] rate);
      case (rate)
         RATE_1_2: return 5'd12;
         RATE_2_3: return 5'd16;
         RATE_3_4: return 5'd18;
         default:  return 5'd20;
      endcase
   endfunction

   function automatic logic [4:0] m_syms(input logic [1:0] rate);
      case (rate)
         RATE_1_2: return 5'd12;
         RATE_2_3: return 5'd8;
         RATE_3_4: return 5'd6;
         default:  return 5'd4;
      endcase
   endfunction

   // Z = 27 * beats_per_sym; the illegal length code never reaches a latched mode
   function automatic logic [1:0] beats_per_sym(input logic [1:0] len);
      return len + 2'd1;
   endfunction

   function automatic logic [5:0] msg_beats(input logic [3:0] m);
      logic [5:0] k;
      logic [5:0] b;
      k = {1'b0, k_syms(m[1:0])};
      b = {4'b0000, beats_per_sym(m[3:2])};
      return k * b;
   endfunction

endpackage

// File: rtl/ldpcenc_ctl_if.sv
// rtl/ldpcenc_ctl_if.sv - command and message-beat handshake into the LDPC encoder controller
interface ldpcenc_ctl_if;
   logic        start;
   logic [3:0]  mode_in;
   logic [26:0] data_in;
   logic        vld_in;
   logic        rdy_in;

   modport master (output start, output mode_in, output data_in, output vld_in, input rdy_in);
   modport slave  (input start, input mode_in, input data_in, input vld_in, output rdy_in);
endinterface

// File: rtl/ldpcenc_ctl.sv
// rtl/ldpcenc_ctl.sv - sequencing controller for the LDPC encoder datapath
module ldpcenc_ctl
   import ldpcenc_pkg::*;
#(
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   ldpcenc_ctl_if.slave cmd,
   output logic [1:0]  state,
   output logic [3:0]  mode,
   output logic [4:0]  cnt_sym,
   output logic [1:0]  cnt_vld,
   output logic [1:0]  cnt_vld_max,
   output logic        clr_acc,
   output logic        vld,
   output logic [26:0] data_r1,
   output logic [26:0] data_r2,
   output logic [26:0] data_r3,
   output logic        vld_out,
   output logic        done,
   output logic        busy
);

   state_t     state_q, state_d;
   logic [5:0] beat_cnt;
   logic [7:0] wait_cnt;
   logic [5:0] msg_total;
   logic [4:0] m_last;
   logic       rdy;
   logic       start_ok;
   logic       accept;
   logic       msg_full;
   logic       wait_done;
   logic       vb_wrap;
   logic       last_prt;

   assign msg_total   = msg_beats(mode);
   assign m_last      = m_syms(mode[1:0]) - 5'd1;
   assign cnt_vld_max = mode[3:2];
   assign msg_full    = (beat_cnt == msg_total);
   assign vb_wrap     = (cnt_vld == cnt_vld_max);
   assign start_ok    = (state_q == ST_IDLE) && cmd.start && (cmd.mode_in[3:2] != LEN_BAD);
   assign accept      = cmd.vld_in && rdy;
   assign wait_done   = (wait_cnt == 8'(WAIT_CYC - 1));
   assign last_prt    = (state_q == ST_PRT) && (cnt_sym == m_last) && vb_wrap;

   assign cmd.rdy_in  = rdy;
   assign state       = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // MSG holds one extra cycle after the last beat lands in data_r1 so the datapath can absorb it
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_ok)        state_d = ST_MSG;
         ST_MSG:  if (vld && msg_full) state_d = ST_WAIT;
         ST_WAIT: if (wait_done)       state_d = ST_PRT;
         default: if (last_prt)        state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rdy  = (state_q == ST_MSG) && !msg_full;
      busy = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode     <= 4'd0;
         cnt_sym  <= 5'd0;
         cnt_vld  <= 2'd0;
         beat_cnt <= 6'd0;
         wait_cnt <= 8'd0;
         clr_acc  <= 1'b0;
         vld      <= 1'b0;
         data_r1  <= 27'd0;
         data_r2  <= 27'd0;
         data_r3  <= 27'd0;
         vld_out  <= 1'b0;
         done     <= 1'b0;
      end else begin
         clr_acc <= start_ok;
         vld     <= accept;
         vld_out <= vld || (state_q == ST_PRT);
         done    <= last_prt;
         if (accept) begin
            data_r3 <= data_r2;
            data_r2 <= data_r1;
            data_r1 <= cmd.data_in;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  mode     <= cmd.mode_in;
                  cnt_sym  <= 5'd0;
                  cnt_vld  <= 2'd0;
                  beat_cnt <= 6'd0;
               end
            end
            ST_MSG: begin
               wait_cnt <= 8'd0;
               // counters name the beat now sitting in data_r1
               if (accept) begin
                  beat_cnt <= beat_cnt + 6'd1;
                  if (beat_cnt == 6'd0) begin
                     cnt_sym <= 5'd0;
                     cnt_vld <= 2'd0;
                  end else if (vb_wrap) begin
                     cnt_sym <= cnt_sym + 5'd1;
                     cnt_vld <= 2'd0;
                  end else begin
                     cnt_vld <= cnt_vld + 2'd1;
                  end
               end
            end
            ST_WAIT: begin
               wait_cnt <= wait_cnt + 8'd1;
               if (wait_done) begin
                  cnt_sym <= 5'd0;
                  cnt_vld <= 2'd0;
               end
            end
            default: begin
               if (last_prt) begin
                  cnt_sym <= 5'd0;
                  cnt_vld <= 2'd0;
               end else if (vb_wrap) begin
                  cnt_sym <= cnt_sym + 5'd1;
                  cnt_vld <= 2'd0;
               end else begin
                  cnt_vld <= cnt_vld + 2'd1;
               end
            end
         endcase
      end
   end

endmodule
